// File: rtl/cdb_pkg.sv
// Shared types and source index map for the Common Data Bus.
package cdb_pkg;

    localparam int ROB_W  = 6;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ROB_W-1:0]  dest_ROB_entry;
        logic [DATA_W-1:0] result;
        logic              branch_result;
    } CDB_packet_t;

    localparam int NUM_CDB_SRC = 6;
    localparam int SRC_ADD0    = 0;
    localparam int SRC_ADD1    = 1;
    localparam int SRC_MULT    = 2;
    localparam int SRC_DIV     = 3;
    localparam int SRC_MEM     = 4;
    localparam int SRC_SHIFT   = 5;

endpackage

// File: rtl/cdb_rr_pick.sv
// Combinational rotate-priority picker: first set request at ptr, ptr+1, ... modulo NUM_SRC.
module cdb_rr_pick #(
    parameter int NUM_SRC = 6,
    parameter int PTR_W   = 3
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    logic [PTR_W:0]   cand_wide;
    logic [PTR_W-1:0] cand;

    // NOTE: every output gets a default before the loop so no path leaves a value unassigned (no latch).
    always_comb begin
        grant     = '0;
        idx       = '0;
        any       = 1'b0;
        cand_wide = '0;
        cand      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Wrap at NUM_SRC, not at 2^PTR_W, so index 5 is followed by 0.
            cand_wide = {1'b0, ptr} + (PTR_W+1)'(i);
            if (cand_wide >= (PTR_W+1)'(NUM_SRC))
                cand_wide = cand_wide - (PTR_W+1)'(NUM_SRC);
            cand = cand_wide[PTR_W-1:0];
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Registered CDB arbiter: bounded fixed priority for the memory unit, round-robin for the rest.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC   = NUM_CDB_SRC,
    parameter int PRIO_SRC  = SRC_MEM,
    parameter int MAX_BURST = 3,
    parameter int PTR_W     = $clog2(NUM_SRC),
    parameter int BURST_W   = $clog2(MAX_BURST + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic [NUM_SRC-1:0] valid_out_bus,
    input  CDB_packet_t        adder_0_out,
    input  CDB_packet_t        adder_1_out,
    input  CDB_packet_t        mult_out,
    input  CDB_packet_t        div_out,
    input  CDB_packet_t        mem_out,
    input  CDB_packet_t        shift_out,
    output logic [NUM_SRC-1:0] yummi_in_bus,
    output logic               cdb_valid_o,
    output CDB_packet_t        cdb_packet_o
);

    localparam logic [NUM_SRC-1:0] PRIO_MASK = NUM_SRC'(1) << PRIO_SRC;

    logic [PTR_W-1:0]   rr_ptr;
    logic [BURST_W-1:0] burst_cnt;

    CDB_packet_t pkts [NUM_SRC];
    assign pkts[SRC_ADD0]  = adder_0_out;
    assign pkts[SRC_ADD1]  = adder_1_out;
    assign pkts[SRC_MULT]  = mult_out;
    assign pkts[SRC_DIV]   = div_out;
    assign pkts[SRC_MEM]   = mem_out;
    assign pkts[SRC_SHIFT] = shift_out;

    logic [NUM_SRC-1:0] rr_grant;
    logic [PTR_W-1:0]   rr_idx;
    logic               rr_any;

    cdb_rr_pick #(.NUM_SRC(NUM_SRC), .PTR_W(PTR_W)) u_rr_pick (
        .req   (valid_out_bus),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    logic others_valid;
    logic prio_win;
    logic rr_win;
    logic grant_any;

    // Memory keeps the bus until it has used its burst, unless nobody else is waiting.
    assign others_valid = |(valid_out_bus & ~PRIO_MASK);
    assign prio_win     = !flush_i && valid_out_bus[PRIO_SRC] &&
                          ((burst_cnt < BURST_W'(MAX_BURST)) || !others_valid);
    assign rr_win       = !flush_i && !prio_win && rr_any;
    assign grant_any    = prio_win || rr_win;

    logic [NUM_SRC-1:0] grant_vec;
    logic [PTR_W-1:0]   grant_idx;

    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        if (prio_win) begin
            grant_vec = PRIO_MASK;
            grant_idx = PTR_W'(PRIO_SRC);
        end else if (rr_win) begin
            grant_vec = rr_grant;
            grant_idx = rr_idx;
        end
    end

    // Consumers must not see a strobe while the arbiter is held in reset.
    assign yummi_in_bus = rst_n ? grant_vec : '0;

    logic [PTR_W-1:0]   rr_ptr_next;
    logic [BURST_W-1:0] burst_next;

    always_comb begin
        rr_ptr_next = rr_ptr;
        if (rr_win)
            rr_ptr_next = (rr_idx == PTR_W'(NUM_SRC - 1)) ? '0 : rr_idx + 1'b1;
    end

    always_comb begin
        burst_next = burst_cnt;
        if (flush_i || rr_win)
            burst_next = '0;
        else if (prio_win)
            burst_next = !others_valid ? '0 :
                         (burst_cnt == BURST_W'(MAX_BURST)) ? burst_cnt : burst_cnt + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            burst_cnt    <= '0;
            cdb_valid_o  <= 1'b0;
            cdb_packet_o <= '0;
        end else begin
            rr_ptr       <= rr_ptr_next;
            burst_cnt    <= burst_next;
            cdb_valid_o  <= grant_any;
            cdb_packet_o <= grant_any ? pkts[grant_idx] : '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: handshake, round-robin wrap, burst limit, flush, reset.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic [5:0]  valid_out_bus;
    logic [5:0]  yummi_in_bus;
    logic        cdb_valid_o;
    CDB_packet_t cdb_packet_o;
    CDB_packet_t pkt_model [6];

    int n_checks = 0;
    int n_pass   = 0;

    cdb_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .valid_out_bus (valid_out_bus),
        .adder_0_out   (pkt_model[0]),
        .adder_1_out   (pkt_model[1]),
        .mult_out      (pkt_model[2]),
        .div_out       (pkt_model[3]),
        .mem_out       (pkt_model[4]),
        .shift_out     (pkt_model[5]),
        .yummi_in_bus  (yummi_in_bus),
        .cdb_valid_o   (cdb_valid_o),
        .cdb_packet_o  (cdb_packet_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One arbitration cycle: drive inputs, check the same-cycle strobe, then the registered result.
    task automatic cyc(input string tag, input logic [5:0] v, input logic fl, input int g);
        logic [5:0]  exp_y;
        CDB_packet_t exp_p;
        exp_y = (g < 0) ? 6'b0 : (6'b1 << g);
        exp_p = (g < 0) ? '0 : pkt_model[g];
        valid_out_bus = v;
        flush_i       = fl;
        #1;
        check({tag, "_yummi"}, yummi_in_bus, exp_y);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, cdb_valid_o, (g >= 0));
        check({tag, "_pkt"}, cdb_packet_o, exp_p);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            pkt_model[i].dest_ROB_entry = 6'(i + 8);
            pkt_model[i].result         = 32'hA000_0000 + i;
            pkt_model[i].branch_result  = i[0];
        end
        pkt_model[0] = '{dest_ROB_entry: 6'd7, result: 32'hDEAD_BEEF, branch_result: 1'b0};

        rst_n         = 1'b0;
        flush_i       = 1'b0;
        valid_out_bus = '0;
        #2;
        check("rst_valid", cdb_valid_o, 1'b0);
        check("rst_pkt", cdb_packet_o, '0);
        check("rst_yummi", yummi_in_bus, '0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single source, one-cycle latency
        cyc("t1", 6'b000001, 1'b0, 0);
        check("t1_ptr", dut.rr_ptr, 1);

        // 2: no mem, round-robin from pointer 0
        cyc("t2_pre", 6'b100000, 1'b0, 5);
        cyc("t2_a", 6'b101111, 1'b0, 0);
        cyc("t2_b", 6'b101111, 1'b0, 1);
        cyc("t2_c", 6'b101111, 1'b0, 2);
        cyc("t2_d", 6'b101111, 1'b0, 3);
        cyc("t2_e", 6'b101111, 1'b0, 5);
        cyc("t2_f", 6'b101111, 1'b0, 0);
        cyc("t2_g", 6'b101111, 1'b0, 1);

        // steer pointer to 5; mem wins the last slot through round-robin
        cyc("t3_p0", 6'b001000, 1'b0, 3);
        cyc("t3_p1", 6'b110000, 1'b0, 4);
        cyc("t3_p2", 6'b110000, 1'b0, 4);
        cyc("t3_p3", 6'b110000, 1'b0, 4);
        check("t3_burst3", dut.burst_cnt, 3);
        cyc("t3_p4", 6'b110000, 1'b0, 4);
        check("t3_ptr5", dut.rr_ptr, 5);
        check("t3_burst0", dut.burst_cnt, 0);

        // 3: modulo-6 wrap
        cyc("t3_a", 6'b100001, 1'b0, 5);
        check("t3_wrap", dut.rr_ptr, 0);
        cyc("t3_b", 6'b100001, 1'b0, 0);
        check("t3_ptr1", dut.rr_ptr, 1);

        // 4: all valid, burst limit of three
        cyc("t4_pre", 6'b100000, 1'b0, 5);
        cyc("t4_a", 6'b111111, 1'b0, 4);
        check("t4_b1", dut.burst_cnt, 1);
        cyc("t4_b", 6'b111111, 1'b0, 4);
        check("t4_b2", dut.burst_cnt, 2);
        cyc("t4_c", 6'b111111, 1'b0, 4);
        check("t4_b3", dut.burst_cnt, 3);
        cyc("t4_d", 6'b111111, 1'b0, 0);
        check("t4_b0", dut.burst_cnt, 0);
        cyc("t4_e", 6'b111111, 1'b0, 4);
        cyc("t4_f", 6'b111111, 1'b0, 4);
        cyc("t4_g", 6'b111111, 1'b0, 4);
        cyc("t4_h", 6'b111111, 1'b0, 1);
        check("t4_ptr", dut.rr_ptr, 2);

        // 5: mem alone is never limited
        for (int i = 0; i < 10; i++) begin
            cyc($sformatf("t5_%0d", i), 6'b010000, 1'b0, 4);
            check($sformatf("t5_burst_%0d", i), dut.burst_cnt, 0);
        end
        check("t5_ptr", dut.rr_ptr, 2);

        // 6: flush mid-burst
        cyc("t6_a", 6'b111111, 1'b0, 4);
        cyc("t6_b", 6'b111111, 1'b0, 4);
        check("t6_b2", dut.burst_cnt, 2);
        check("t6_held", cdb_valid_o, 1'b1);
        cyc("t6_flush", 6'b111111, 1'b1, -1);
        check("t6_burst", dut.burst_cnt, 0);
        check("t6_ptr", dut.rr_ptr, 2);
        cyc("t6_c", 6'b111111, 1'b0, 4);

        // 7: asynchronous reset mid-burst
        cyc("t7_a", 6'b111111, 1'b0, 4);
        check("t7_b2", dut.burst_cnt, 2);
        check("t7_v1", cdb_valid_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_valid", cdb_valid_o, 1'b0);
        check("t7_rst_pkt", cdb_packet_o, '0);
        check("t7_rst_yummi", yummi_in_bus, '0);
        check("t7_rst_burst", dut.burst_cnt, 0);
        check("t7_rst_ptr", dut.rr_ptr, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc("t7_b", 6'b111111, 1'b0, 4);
        cyc("t7_c", 6'b111111, 1'b0, 4);
        cyc("t7_d", 6'b111111, 1'b0, 4);
        cyc("t7_e", 6'b111111, 1'b0, 0);
        check("t7_ptr", dut.rr_ptr, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
